// File: rtl/minirv_ctrl_fsm.sv
// minirv_ctrl_fsm: multi-cycle FETCH/DECODE/MEM/WB sequencer with halt on ebreak or illegal decode.
// Define CTRL_PERF_CNT_EN to add the 64-bit cycle_cnt / instret_cnt performance counters.
module minirv_ctrl_fsm (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        ir_we,
  input  logic        dec_reg_write,
  input  logic        dec_mem_read,
  input  logic        dec_mem_write,
  input  logic        dec_ebreak,
  input  logic        dec_illegal,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_we,
  output logic        pc_we,
  output logic        halt,
`ifdef CTRL_PERF_CNT_EN
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt,
`endif
  output logic        trap_code
);

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t state_q, state_d;
  logic   f_rw, f_mr, f_mw;
  logic   trap_q;
  logic   abort;

  // A read+write decode is as unusable as an illegal one.
  assign abort = dec_illegal | (dec_mem_read & dec_mem_write);

  // NOTE: state registers use non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  // NOTE: flags are reset too, so nothing downstream ever sees an X after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_rw   <= 1'b0;
      f_mr   <= 1'b0;
      f_mw   <= 1'b0;
      trap_q <= 1'b0;
    end else if (state_q == S_DECODE) begin
      f_rw   <= dec_reg_write;
      f_mr   <= dec_mem_read;
      f_mw   <= dec_mem_write;
      trap_q <= abort;
    end
  end

  // NOTE: state_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (imem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (abort)                              state_d = S_HALT;
        else if (dec_ebreak)                    state_d = S_HALT;
        else if (dec_mem_read || dec_mem_write) state_d = S_MEM;
        else                                    state_d = S_WB;
      end
      S_MEM:    if (dmem_ready) state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_RESET;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    halt      = 1'b0;
    trap_code = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = f_mw & ~f_mr;
      end
      S_WB: begin
        rf_we = f_rw;
        pc_we = 1'b1;
      end
      S_HALT: begin
        halt      = 1'b1;
        trap_code = trap_q;
      end
      default: ;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_q != S_RESET && state_q != S_HALT) cycle_cnt <= cycle_cnt + 64'd1;
      if (state_q == S_WB) instret_cnt <= instret_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_minirv_ctrl_fsm.sv
// Testbench for minirv_ctrl_fsm: per-instruction cycle traces built from the sequencing rules
// are replayed against the DUT with random waits and random noise on ignored inputs.
module tb_minirv_ctrl_fsm;

  logic        clk;
  logic        rst;
  logic        imem_req, imem_ready, ir_we;
  logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_ebreak, dec_illegal;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        rf_we, pc_we, halt, trap_code;
`ifdef CTRL_PERF_CNT_EN
  logic [63:0] cycle_cnt, instret_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  minirv_ctrl_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_ready    (imem_ready),
    .ir_we         (ir_we),
    .dec_reg_write (dec_reg_write),
    .dec_mem_read  (dec_mem_read),
    .dec_mem_write (dec_mem_write),
    .dec_ebreak    (dec_ebreak),
    .dec_illegal   (dec_illegal),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_ready    (dmem_ready),
    .rf_we         (rf_we),
    .pc_we         (pc_we),
    .halt          (halt),
`ifdef CTRL_PERF_CNT_EN
    .cycle_cnt     (cycle_cnt),
    .instret_cnt   (instret_cnt),
`endif
    .trap_code     (trap_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected cycle: inputs to drive and outputs {imem_req,ir_we,dmem_req,dmem_we,rf_we,pc_we,halt,trap_code}.
  typedef struct {
    logic            imem_ready;
    logic            dmem_ready;
    logic [4:0]      dec;
    logic [7:0]      exp;
    longint unsigned ecyc;
    longint unsigned eret;
  } cyc_t;

  cyc_t            q[$];
  longint unsigned m_cyc;
  longint unsigned m_ret;

  function automatic logic [7:0] outs();
    return {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halt, trap_code};
  endfunction

  function automatic logic rnd1();
    return 1'($urandom);
  endfunction

  function automatic logic [4:0] rnd5();
    return 5'($urandom);
  endfunction

  function automatic void push(logic ir, logic dr, logic [4:0] dec, logic [7:0] exp,
                               bit active, bit wb);
    cyc_t c;
    c.imem_ready = ir;
    c.dmem_ready = dr;
    c.dec        = dec;
    c.exp        = exp;
    c.ecyc       = m_cyc;
    c.eret       = m_ret;
    q.push_back(c);
    if (active) m_cyc++;
    if (wb)     m_ret++;
  endfunction

  // Expected trace of one instruction; a halting one is followed by 10 frozen HALT cycles.
  function automatic void add_instr(logic rw, logic mr, logic mw, logic eb, logic il,
                                    int wi, int wd);
    logic abort;
    for (int i = 0; i < wi; i++) push(1'b0, rnd1(), rnd5(), 8'b1000_0000, 1, 0);
    push(1'b1, rnd1(), rnd5(), 8'b1100_0000, 1, 0);
    push(rnd1(), rnd1(), {rw, mr, mw, eb, il}, 8'b0000_0000, 1, 0);
    abort = il | (mr & mw);
    if (abort || eb) begin
      for (int i = 0; i < 10; i++) push(rnd1(), rnd1(), rnd5(), {6'b0, 1'b1, abort}, 0, 0);
      return;
    end
    if (mr || mw) begin
      for (int i = 0; i < wd; i++) push(rnd1(), 1'b0, rnd5(), {2'b00, 1'b1, mw, 4'b0}, 1, 0);
      push(rnd1(), 1'b1, rnd5(), {2'b00, 1'b1, mw, 4'b0}, 1, 0);
    end
    push(rnd1(), rnd1(), rnd5(), {4'b0, rw, 1'b1, 2'b00}, 1, 1);
  endfunction

  task automatic play(input string name);
    cyc_t       c;
    logic [7:0] got;
    int         idx;
    idx = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(posedge clk);
      #1;
      imem_ready = c.imem_ready;
      dmem_ready = c.dmem_ready;
      {dec_reg_write, dec_mem_read, dec_mem_write, dec_ebreak, dec_illegal} = c.dec;
      #1;
      got = outs();
      n_tests++;
      if (got !== c.exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d outputs: got %b expected %b", name, idx, got, c.exp);
      end
`ifdef CTRL_PERF_CNT_EN
      n_tests++;
      if (cycle_cnt !== 64'(c.ecyc) || instret_cnt !== 64'(c.eret)) begin
        n_fail++;
        $display("FAIL %s cycle %0d counters: got %0d/%0d expected %0d/%0d",
                 name, idx, cycle_cnt, instret_cnt, c.ecyc, c.eret);
      end
`endif
      idx++;
    end
  endtask

  // Leaves the bench in the RESET-state cycle with the model cleared.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_cyc = 0;
    m_ret = 0;
    q.delete();
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst        = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    {dec_reg_write, dec_mem_read, dec_mem_write, dec_ebreak, dec_illegal} = 5'b11111;
    repeat (3) @(posedge clk);
    #1;
    got = outs();
    n_tests++;
    if (got !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_hold outputs: got %b expected %b", got, 8'h00);
    end
    rst = 1'b0;
    #1;
    got = outs();
    n_tests++;
    if (got !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state outputs: got %b expected %b", got, 8'h00);
    end
`ifdef CTRL_PERF_CNT_EN
    n_tests++;
    if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycle_cnt, instret_cnt);
    end
`endif
    @(posedge clk);
    #1;
    imem_ready = 1'b0;
    #1;
    got = outs();
    n_tests++;
    if (got !== 8'h80) begin
      n_fail++;
      $display("FAIL first_fetch outputs: got %b expected %b", got, 8'h80);
    end
  endtask

  task automatic test_alu();
    do_reset();
    add_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    push(1'b0, rnd1(), rnd5(), 8'b1000_0000, 1, 0);
    play("alu_zero_wait");
  endtask

  task automatic test_store();
    do_reset();
    add_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 2);
    push(1'b0, rnd1(), rnd5(), 8'b1000_0000, 1, 0);
    play("store_wait2");
  endtask

  task automatic test_load();
    do_reset();
    add_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
    push(1'b0, rnd1(), rnd5(), 8'b1000_0000, 1, 0);
    play("load_iwait1");
  endtask

  task automatic test_ebreak();
    do_reset();
    add_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    add_instr(rnd1(), 1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
    play("ebreak");
  endtask

  task automatic test_abort();
    do_reset();
    add_instr(rnd1(), rnd1(), rnd1(), rnd1(), 1'b1, 0, 0);
    play("illegal");
    do_reset();
    add_instr(rnd1(), 1'b1, 1'b1, rnd1(), 1'b0, 2, 0);
    play("read_write_conflict");
  endtask

  task automatic test_rst_in_mem();
    logic [7:0] got;
    do_reset();
    add_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 5);
    q = q[0:3];
    play("pre_reset_mem");
    @(posedge clk);
    #1;
    rst        = 1'b1;
    dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    got = outs();
    n_tests++;
    if (got !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_mem outputs: got %b expected %b", got, 8'h00);
    end
`ifdef CTRL_PERF_CNT_EN
    n_tests++;
    if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
      n_fail++;
      $display("FAIL rst_mid_mem counters: got %0d/%0d expected 0/0", cycle_cnt, instret_cnt);
    end
`endif
    m_cyc = 0;
    m_ret = 0;
    q.delete();
    add_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    play("post_reset_alu");
  endtask

  task automatic test_random();
    int kind;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      add_instr(rnd1(), kind == 1, kind == 2, 1'b0, 1'b0,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    kind = int'($urandom_range(0, 2));
    if (kind == 0)      add_instr(rnd1(), 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    else if (kind == 1) add_instr(rnd1(), rnd1(), rnd1(), rnd1(), 1'b1, 0, 0);
    else                add_instr(rnd1(), 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    play("random_stream");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int n = 0; n < 6; n++) add_instr(1'b1, n % 3 == 1, n % 3 == 2, 1'b0, 1'b0, 0, 0);
    push(1'b0, rnd1(), rnd5(), 8'b1000_0000, 1, 0);
    play("back_to_back");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    {dec_reg_write, dec_mem_read, dec_mem_write, dec_ebreak, dec_illegal} = 5'b0;
    m_cyc = 0;
    m_ret = 0;
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_ebreak();
    test_abort();
    test_rst_in_mem();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
